switch_debounce: RTL and testbench

//   Conditions raw slide-switch inputs before they reach the switch PIO's
//   in_port. Each bit is passed through a 2-FF synchronizer and then a
//   per-bit stability counter, so that sw_clean holds glitch-free levels.
//   Per-bit rise/fall pulses and a combined change pulse are also produced
//   for edge-capture or interrupt logic.
//

---
 rtl/switch_debounce.sv | 91 +++++++++
 tb/tb_switch_debounce.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Slide-switch conditioner: 2-FF synchronizer followed by a per-bit stability
// counter, with registered rise/fall pulses and a combined change pulse.
module switch_debounce_bit #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Accept fires on the cycle the synced level has differed for STABLE_CYCLES edges.
    assign accept = (sync != clean) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == clean) begin
                cnt <= '0;
            end else if (accept) begin
                clean <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module switch_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);
    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .sync  (sync2[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .accept(accept[i])
        );
    end

    // Registered from the same accept terms so it lines up with the per-bit pulses.
    always_ff @(posedge clk) begin
        if (reset) sw_changed <= 1'b0;
        else       sw_changed <= |accept;
    end
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench: stimulus queues expected accept events, a negedge monitor
// pops and checks them whenever the DUT pulses.
module tb_switch_debounce;
    localparam int W  = 8;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean, sw_rise, sw_fall;
    logic         sw_changed;

    switch_debounce #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           edge_no;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Delay from the edge after which sw_raw is driven to the accept edge.
    task automatic expect_ev(input logic [W-1:0] c, input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e.edge_no = edge_n + 2 + SC;
        e.clean   = c;
        e.rise    = r;
        e.fall    = f;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if ((|sw_rise) || (|sw_fall) || sw_changed) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: rise=%0h fall=%0h changed=%0b at edge %0d",
                         sw_rise, sw_fall, sw_changed, edge_n);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_edge", 32'(edge_n), 32'(e.edge_no));
                chk("event_clean", 32'(sw_clean), 32'(e.clean));
                chk("event_rise", 32'(sw_rise), 32'(e.rise));
                chk("event_fall", 32'(sw_fall), 32'(e.fall));
                chk("event_changed", 32'(sw_changed), 32'd1);
            end
        end
    end

    initial begin
        int n;
        reset  = 1'b1;
        sw_raw = '0;
        step(3);
        chk("reset_clean", 32'(sw_clean), 32'h0);
        chk("reset_rise", 32'(sw_rise), 32'h0);
        chk("reset_fall", 32'(sw_fall), 32'h0);
        chk("reset_changed", 32'(sw_changed), 32'h0);
        reset = 1'b0;

        // 1: idle with all switches low
        for (int i = 0; i < 4; i++) begin
            step(5);
            chk("idle_clean", 32'(sw_clean), 32'h0);
        end

        // 2: single clean rise on bit 0
        sw_raw = 8'h01;
        expect_ev(8'h01, 8'h01, 8'h00);
        step(10);
        chk("t2_clean", 32'(sw_clean), 32'h01);

        // 3: 3-cycle glitch on bit 3 is rejected
        sw_raw = 8'h09;
        step(3);
        sw_raw = 8'h01;
        step(10);
        chk("t3_clean", 32'(sw_clean), 32'h01);

        // 4: bouncing bit 7 then settling high
        for (int i = 0; i < 2; i++) begin
            sw_raw = 8'h81;
            step(2);
            sw_raw = 8'h01;
            step(2);
        end
        sw_raw = 8'h81;
        expect_ev(8'h81, 8'h80, 8'h00);
        step(10);
        chk("t4_clean", 32'(sw_clean), 32'h81);

        // 5: settle all high, then all fall together
        sw_raw = 8'hFF;
        expect_ev(8'hFF, 8'h7E, 8'h00);
        step(10);
        chk("t5_clean_hi", 32'(sw_clean), 32'hFF);
        sw_raw = 8'h00;
        expect_ev(8'h00, 8'h00, 8'hFF);
        step(10);
        chk("t5_clean_lo", 32'(sw_clean), 32'h00);

        // 6: reset while bit 4 is mid-count
        sw_raw = 8'h10;
        n = edge_n;
        step(3);
        reset = 1'b1;
        step(1);
        chk("t6_rst_clean", 32'(sw_clean), 32'h0);
        chk("t6_rst_rise", 32'(sw_rise), 32'h0);
        chk("t6_rst_fall", 32'(sw_fall), 32'h0);
        chk("t6_rst_changed", 32'(sw_changed), 32'h0);
        reset = 1'b0;
        expect_ev(8'h10, 8'h10, 8'h00);
        chk("t6_rst_edge", 32'(q[q.size()-1].edge_no), 32'(n + 10));
        step(12);
        chk("t6_clean", 32'(sw_clean), 32'h10);

        step(5);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_event: expected clean=%0h rise=%0h fall=%0h at edge %0d, not seen",
                     e.clean, e.rise, e.fall, e.edge_no);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
